// File: rtl/freq_meter.sv
// Frequency meter: counts rising edges of sig_in over a GATE_CYCLES window of fin.
// Optional FMETER_BCD_EN adds a serial binary-to-BCD converter and a bcd output.
module freq_meter #(
  parameter logic [31:0] GATE_CYCLES = 32'd50000000,
  parameter int          CNT_W       = 32
) (
  input  logic             fin,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq,
  output logic             valid,
  output logic             ovf,
  output logic             busy,
`ifdef FMETER_BCD_EN
  output logic [31:0]      bcd,
`endif
  output logic [1:0]       state_dbg
);

  // valid is a one-cycle, unqualified pulse: there is no ready, the consumer
  // must capture freq/ovf in the cycle valid is high or read the held values later.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    DONE = 2'd2,
    CONV = 2'd3
  } state_t;

  state_t           state, state_next;
  logic             s1, s2, s3;
  logic             rise;
  logic [31:0]      gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic             ovf_int;

`ifdef FMETER_BCD_EN
  logic [CNT_W-1:0] lat_cnt;
  logic             lat_ovf;
  logic             lat_big;
  logic [26:0]      bin_sr;
  logic [31:0]      bcd_sr;
  logic [4:0]       conv_cnt;
  logic [31:0]      ext_cnt;

  assign ext_cnt = 32'(edge_cnt);

  // One double-dabble step: correct each digit, then shift in the next binary bit.
  function automatic logic [31:0] dd_step(input logic [31:0] b, input logic bit_in);
    logic [31:0] a;
    a = b;
    for (int i = 0; i < 8; i++) begin
      if (a[4*i +: 4] >= 4'd5) a[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return {a[30:0], bit_in};
  endfunction
`endif

  assign rise      = s2 & ~s3;
  assign state_dbg = state;

  always_ff @(posedge fin) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge fin) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      IDLE: if (en) state_next = GATE;
      GATE: begin
        busy = 1'b1;
        if (gate_cnt == GATE_CYCLES - 32'd1) state_next = DONE;
      end
      DONE: begin
`ifdef FMETER_BCD_EN
        busy       = 1'b1;
        state_next = CONV;
`else
        state_next = en ? GATE : IDLE;
`endif
      end
      CONV: begin
`ifdef FMETER_BCD_EN
        busy = 1'b1;
        if (conv_cnt == 5'd26) state_next = en ? GATE : IDLE;
`else
        state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge fin) begin
    if (!rst_n) begin
      gate_cnt <= 32'd0;
      edge_cnt <= '0;
      ovf_int  <= 1'b0;
      freq     <= '0;
      ovf      <= 1'b0;
      valid    <= 1'b0;
`ifdef FMETER_BCD_EN
      bcd      <= 32'd0;
      lat_cnt  <= '0;
      lat_ovf  <= 1'b0;
      lat_big  <= 1'b0;
      bin_sr   <= 27'd0;
      bcd_sr   <= 32'd0;
      conv_cnt <= 5'd0;
`endif
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          gate_cnt <= 32'd0;
          edge_cnt <= '0;
          ovf_int  <= 1'b0;
        end
        GATE: begin
          gate_cnt <= gate_cnt + 32'd1;
          // Saturate instead of wrapping; ovf_int records that an edge was lost.
          if (rise) begin
            if (&edge_cnt) ovf_int  <= 1'b1;
            else           edge_cnt <= edge_cnt + 1'b1;
          end
        end
        DONE: begin
          gate_cnt <= 32'd0;
          edge_cnt <= '0;
          ovf_int  <= 1'b0;
`ifdef FMETER_BCD_EN
          lat_cnt  <= edge_cnt;
          lat_ovf  <= ovf_int;
          lat_big  <= ext_cnt > 32'd99999999;
          bin_sr   <= ext_cnt[26:0];
          bcd_sr   <= 32'd0;
          conv_cnt <= 5'd0;
`else
          freq     <= edge_cnt;
          ovf      <= ovf_int;
          valid    <= 1'b1;
`endif
        end
        CONV: begin
`ifdef FMETER_BCD_EN
          conv_cnt <= conv_cnt + 5'd1;
          bcd_sr   <= dd_step(bcd_sr, bin_sr[26]);
          bin_sr   <= {bin_sr[25:0], 1'b0};
          if (conv_cnt == 5'd26) begin
            freq  <= lat_cnt;
            ovf   <= lat_ovf;
            bcd   <= lat_big ? 32'h99999999 : dd_step(bcd_sr, bin_sr[26]);
            valid <= 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter (GATE_CYCLES=100, CNT_W=4): window results
// are predicted from the stimulus period and checked through an expected queue.
module tb_freq_meter;

  localparam int          W = 4;
  localparam logic [31:0] G = 32'd100;

  logic         fin = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         sig_in = 1'b0;
  logic [W-1:0] freq;
  logic         valid;
  logic         ovf;
  logic         busy;
  logic [1:0]   state_dbg;
`ifdef FMETER_BCD_EN
  logic [31:0]  bcd;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int valid_seen = 0;
  int vcyc_q[$];
  logic [W:0] exp_q[$];

  int   sig_period = 0;
  logic sig_level = 1'b0;

  freq_meter #(.GATE_CYCLES(G), .CNT_W(W)) dut (
    .fin(fin),
    .rst_n(rst_n),
    .en(en),
    .sig_in(sig_in),
    .freq(freq),
    .valid(valid),
    .ovf(ovf),
    .busy(busy),
`ifdef FMETER_BCD_EN
    .bcd(bcd),
`endif
    .state_dbg(state_dbg)
  );

  // Clock and cycle counter
  always #5 fin = ~fin;
  always @(posedge fin) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge fin);
      #2;
    end
  endtask

  task automatic wait_valids(input int target, input int budget);
    int t = 0;
    while (valid_seen < target && t < budget) begin
      tick();
      t++;
    end
    if (valid_seen < target) check("valid_timeout", valid_seen, target);
  endtask

  function automatic logic [W:0] expect_for(input int period);
    int n;
    n = (period == 0) ? 0 : int'(G) / period;
    if (n > 15) return {1'b1, 4'hf};
    return {1'b0, 4'(n)};
  endfunction

  // Square-wave source, changes on the falling edge of fin
  initial begin
    int ph = 0;
    forever begin
      @(negedge fin);
      if (sig_period == 0) begin
        sig_in = sig_level;
      end else begin
        if (ph >= sig_period) ph = 0;
        sig_in = (ph < sig_period / 2);
        ph++;
      end
    end
  end

  // Scoreboard: each valid pulse pops one expected {ovf, freq}
  initial begin
    logic [W:0] e;
    forever begin
      @(negedge fin);
      if (valid === 1'b1) begin
        valid_seen++;
        vcyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("result", {ovf, freq}, e);
        end
      end
    end
  end

  // Run n_win back-to-back windows on a settled pattern, then go idle.
  task automatic run_windows(input int period, input logic level, input int n_win);
    int base;
    int c0;
    sig_period = period;
    sig_level  = level;
    en = 1'b0;
    tick(20);
    for (int i = 0; i < n_win; i++) exp_q.push_back(expect_for(period));
    base = valid_seen;
    c0   = cyc;
    en   = 1'b1;
    if (n_win == 1) tick(2);
    else wait_valids(base + n_win - 1, 120 * n_win);
    en = 1'b0;
    wait_valids(base + n_win, 150);
    if (valid_seen == base + n_win) begin
      check("first_latency", vcyc_q[base] - c0, 102);
      for (int i = 1; i < n_win; i++)
        check("window_period", vcyc_q[base + i] - vcyc_q[base + i - 1], 101);
    end
    tick(5);
    check("idle_busy", busy, 0);
    check("idle_state", state_dbg, 0);
  endtask

  initial begin
    int base;
    int c1;
    int lows;
    int t;

    rst_n = 1'b0;
    tick(3);
    check("rst_freq", freq, 0);
    check("rst_valid", valid, 0);
    check("rst_ovf", ovf, 0);
    check("rst_busy", busy, 0);
    check("rst_state", state_dbg, 0);
    rst_n = 1'b1;
    tick(2);

    run_windows(10, 1'b0, 3);
    run_windows(0, 1'b0, 1);
    run_windows(0, 1'b1, 1);

    run_windows(4, 1'b0, 1);
    tick(10);
    check("hold_freq_sat", freq, 15);
    check("hold_ovf_sat", ovf, 1);
    run_windows(20, 1'b0, 1);
    check("ovf_cleared", ovf, 0);

    // en dropped 30 cycles into a window: that window still publishes, then nothing
    sig_period = 4;
    tick(20);
    exp_q.push_back(expect_for(4));
    base = valid_seen;
    en = 1'b1;
    tick(30);
    check("busy_in_window", busy, 1);
    en = 1'b0;
    wait_valids(base + 1, 200);
    tick(5);
    check("drop_busy", busy, 0);
    tick(250);
    check("drop_single_valid", valid_seen, base + 1);
    check("drop_hold_freq", freq, 15);
    check("drop_hold_ovf", ovf, 1);

    // Reset 50+ cycles into a window, taken while sig_in has been low for 3 samples
    sig_period = 10;
    tick(20);
    base = valid_seen;
    en = 1'b1;
    tick(50);
    lows = 0;
    t = 0;
    while (lows < 3 && t < 30) begin
      tick();
      t++;
      lows = sig_in ? 0 : lows + 1;
    end
    rst_n = 1'b0;
    tick();
    check("midrst_freq", freq, 0);
    check("midrst_ovf", ovf, 0);
    check("midrst_busy", busy, 0);
    check("midrst_state", state_dbg, 0);
    exp_q.push_back(expect_for(10));
    c1 = cyc;
    rst_n = 1'b1;
    tick(3);
    en = 1'b0;
    wait_valids(base + 1, 200);
    if (valid_seen == base + 1) check("midrst_latency", vcyc_q[base] - c1, 102);
    tick(150);
    check("midrst_single_valid", valid_seen, base + 1);
    check("exp_q_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
